blackjack_table: RTL

Parametrised blackjack round controller for one dealer and `NUM_PLAYERS` players. It is the successor to the single-player `blackjackGame`. It pulls cards from an external card source over a valid/ready handshake and scores each hand with soft-ace handling. It sequences the dealer and every player through a round with per-player hit/stand keys, then reports a per-player result. It sits between the board keys/shuffler and the seven-segment/LED display logic.

---
 rtl/blackjack_table_if.sv | 16 +
 rtl/blackjack_table.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_table_if.sv
// Card-source handshake between the shuffler and the blackjack table.
//
// The card source (master) presents a rank with cardValid. The table (slave)
// raises cardReady when it wants a card. A card moves on every clock edge
// where both are high.
//   cardValid  master->slave  a card is present on cardRank
//   cardRank   master->slave  1 = ace, 2..10 = pips, 11..13 = face
//   cardReady  slave->master  the table will take a card this cycle
interface blackjack_table_if;
  logic       cardValid;
  logic [3:0] cardRank;
  logic       cardReady;

  modport master (output cardValid, output cardRank, input cardReady);
  modport slave  (input cardValid, input cardRank, output cardReady);
endinterface

// File: rtl/blackjack_table.sv
// Blackjack round controller for one dealer and NUM_PLAYERS seats.
//
// The block pulls cards from a card source and scores every hand with
// soft-ace handling. It steps the dealer and each seat through a round
// under the hit/stand keys, then publishes a result for each seat.
//
// Ports
//   clk, reset  system clock; synchronous active-high reset
//   dealKey     active-low deal key (starts a round from idle/done)
//   playerKeys  active-low keys, {stand,hit} of seat p at [2p+1:2p]
//   card        card-source handshake (slave side)
//   playerSums  best sum of seat p at [5p+4:5p]
//   dealerSum   dealer best sum
//   gameState   FSM state encoding
//   whoseTurn   seat being served; NUM_PLAYERS means the dealer
//   results     per seat: 0 pending, 1 lose, 2 push, 3 win
module blackjack_table #(
  parameter int NUM_PLAYERS   = 2,
  parameter int CHARLIE_CARDS = 5,
  parameter int DEALER_STAND  = 17
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dealKey,
  input  logic [2*NUM_PLAYERS-1:0]   playerKeys,
  blackjack_table_if.slave           card,
  output logic [5*NUM_PLAYERS-1:0]   playerSums,
  output logic [4:0]                 dealerSum,
  output logic [3:0]                 gameState,
  output logic [2:0]                 whoseTurn,
  output logic [2*NUM_PLAYERS-1:0]   results
);

  typedef enum logic [3:0] {
    S_IDLE            = 4'd0,
    S_DEAL_DEALER1    = 4'd1,
    S_DEAL_DEALER2    = 4'd2,
    S_CHECK_DEALER_BJ = 4'd3,
    S_DEAL_P1         = 4'd4,
    S_DEAL_P2         = 4'd5,
    S_CHECK_PLAYER    = 4'd6,
    S_WAIT_INPUT      = 4'd7,
    S_DEAL_HIT        = 4'd8,
    S_NEXT_PLAYER     = 4'd9,
    S_DEALER_PLAY     = 4'd10,
    S_RESOLVE         = 4'd11,
    S_DONE            = 4'd12
  } state_t;

  // The dealer's hand is stored in the slot just after the last seat, so
  // whoseTurn always selects the hand that receives the next card.
  localparam int         SEATS       = NUM_PLAYERS + 1;
  localparam logic [2:0] DEALER_SEAT = 3'(NUM_PLAYERS);
  localparam logic [2:0] LAST_PLAYER = 3'(NUM_PLAYERS - 1);

  localparam logic [1:0] R_PENDING = 2'd0;
  localparam logic [1:0] R_LOSE    = 2'd1;
  localparam logic [1:0] R_PUSH    = 2'd2;
  localparam logic [1:0] R_WIN     = 2'd3;

  state_t                   state, state_next;
  logic [2:0]               turn, turn_next;
  logic [4:0]               hard      [SEATS];
  logic [4:0]               hard_next [SEATS];
  logic                     ace       [SEATS];
  logic                     ace_next  [SEATS];
  logic [3:0]               cnt       [SEATS];
  logic [3:0]               cnt_next  [SEATS];
  logic [4:0]               best      [SEATS];
  logic [4:0]               best_next [SEATS];
  logic [2*NUM_PLAYERS-1:0] res, res_next;
  logic                     ready, ready_next;

  logic                     deal_s1, deal_s2, deal_press;
  logic [2*NUM_PLAYERS-1:0] keys_s1, keys_s2, key_press;

  logic       accept;
  logic [4:0] cur_hard, cur_best, add_hard, add_best;
  logic       cur_ace, add_ace;
  logic [3:0] cur_cnt, add_cnt;
  logic       cur_hit, cur_stand;
  logic       all_decided;
  logic       seat_done;
  logic [1:0] seat_result;
  logic [4:0] dealer_best;

  // Ace counts 1, faces count 10.
  function automatic logic [4:0] card_value(input logic [3:0] rank);
    if (rank > 4'd10) return 5'd10;
    return {1'b0, rank};
  endfunction

  // One ace may be promoted to 11 when that does not bust the hand.
  function automatic logic [4:0] best_of(input logic [4:0] h, input logic a);
    if (a && (h <= 5'd11)) return h + 5'd10;
    return h;
  endfunction

  assign accept         = ready & card.cardValid;
  assign card.cardReady = ready;
  assign gameState      = state;
  assign whoseTurn      = turn;
  assign results        = res;
  assign dealerSum      = best[NUM_PLAYERS];
  assign dealer_best    = best[NUM_PLAYERS];

  // Seat sums are published straight from the per-hand best-sum registers.
  always_comb begin
    playerSums = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      playerSums[5*p +: 5] = best[p];
    end
  end

  // Pull out the hand and key presses belonging to the seat being served,
  // and work out what that hand would become with the card on offer.
  always_comb begin
    cur_hard  = '0;
    cur_ace   = 1'b0;
    cur_cnt   = '0;
    cur_best  = '0;
    cur_hit   = 1'b0;
    cur_stand = 1'b0;
    for (int i = 0; i < SEATS; i++) begin
      if (3'(i) == turn) begin
        cur_hard = hard[i];
        cur_ace  = ace[i];
        cur_cnt  = cnt[i];
        cur_best = best[i];
      end
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (3'(p) == turn) begin
        cur_hit   = key_press[2*p];
        cur_stand = key_press[2*p+1];
      end
    end
    add_hard = cur_hard + card_value(card.cardRank);
    add_ace  = cur_ace | (card.cardRank == 4'd1);
    add_cnt  = (cur_cnt == 4'hF) ? cur_cnt : cur_cnt + 4'd1;
    add_best = best_of(add_hard, add_ace);
  end

  // Next-state logic. Card accepts are handled once up front for whichever
  // hand is being served; the state case then only decides where to go and
  // which results to record. cardReady is computed for the state being
  // entered so the registered output is correct on the very next cycle.
  always_comb begin
    state_next  = state;
    turn_next   = turn;
    res_next    = res;
    seat_done   = 1'b0;
    seat_result = R_PENDING;
    for (int i = 0; i < SEATS; i++) begin
      hard_next[i] = hard[i];
      ace_next[i]  = ace[i];
      cnt_next[i]  = cnt[i];
      best_next[i] = best[i];
    end

    if (accept) begin
      for (int i = 0; i < SEATS; i++) begin
        if (3'(i) == turn) begin
          hard_next[i] = add_hard;
          ace_next[i]  = add_ace;
          cnt_next[i]  = add_cnt;
          best_next[i] = add_best;
        end
      end
    end

    case (state)
      S_IDLE, S_DONE: begin
        if (deal_press) begin
          for (int i = 0; i < SEATS; i++) begin
            hard_next[i] = '0;
            ace_next[i]  = 1'b0;
            cnt_next[i]  = '0;
            best_next[i] = '0;
          end
          res_next   = '0;
          turn_next  = DEALER_SEAT;
          state_next = S_DEAL_DEALER1;
        end
      end
      S_DEAL_DEALER1: if (accept) state_next = S_DEAL_DEALER2;
      S_DEAL_DEALER2: if (accept) state_next = S_CHECK_DEALER_BJ;
      S_CHECK_DEALER_BJ: begin
        if ((cur_best == 5'd21) && (cur_cnt == 4'd2)) begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            res_next[2*p +: 2] = R_LOSE;
          end
          state_next = S_DONE;
        end else begin
          turn_next  = '0;
          state_next = S_DEAL_P1;
        end
      end
      S_DEAL_P1: if (accept) state_next = S_DEAL_P2;
      S_DEAL_P2: if (accept) state_next = S_CHECK_PLAYER;
      S_CHECK_PLAYER: begin
        // Natural first, then bust, then the card-count win.
        seat_done = 1'b1;
        if ((cur_best == 5'd21) && (cur_cnt == 4'd2)) begin
          seat_result = R_WIN;
        end else if (cur_best > 5'd21) begin
          seat_result = R_LOSE;
        end else if (cur_cnt == 4'(CHARLIE_CARDS)) begin
          seat_result = R_WIN;
        end else begin
          seat_done = 1'b0;
        end
        if (seat_done) begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (3'(p) == turn) res_next[2*p +: 2] = seat_result;
          end
          state_next = S_NEXT_PLAYER;
        end else begin
          state_next = S_WAIT_INPUT;
        end
      end
      S_WAIT_INPUT: begin
        if (cur_stand) begin
          state_next = S_NEXT_PLAYER;
        end else if (cur_hit) begin
          state_next = S_DEAL_HIT;
        end
      end
      S_DEAL_HIT: if (accept) state_next = S_CHECK_PLAYER;
      S_NEXT_PLAYER: begin
        if (turn == LAST_PLAYER) begin
          turn_next  = DEALER_SEAT;
          state_next = S_DEALER_PLAY;
        end else begin
          turn_next  = turn + 3'd1;
          state_next = S_DEAL_P1;
        end
      end
      S_DEALER_PLAY: begin
        // cardReady already encodes "dealer still needs cards".
        if (!ready) state_next = S_RESOLVE;
      end
      S_RESOLVE: begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (res[2*p +: 2] == R_PENDING) begin
            if ((dealer_best > 5'd21) || (best[p] > dealer_best)) begin
              res_next[2*p +: 2] = R_WIN;
            end else if (best[p] == dealer_best) begin
              res_next[2*p +: 2] = R_PUSH;
            end else begin
              res_next[2*p +: 2] = R_LOSE;
            end
          end
        end
        state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase

    // The dealer skips drawing when no seat is left to play against.
    all_decided = 1'b1;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (res_next[2*p +: 2] == R_PENDING) all_decided = 1'b0;
    end

    case (state_next)
      S_DEAL_DEALER1, S_DEAL_DEALER2, S_DEAL_P1, S_DEAL_P2, S_DEAL_HIT:
        ready_next = 1'b1;
      S_DEALER_PLAY:
        ready_next = !all_decided && (best_next[NUM_PLAYERS] < 5'(DEALER_STAND));
      default:
        ready_next = 1'b0;
    endcase
  end

  // State, hands and key samplers. A press is the falling edge of the
  // registered key sample, itself registered, so a held key makes one press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      turn       <= DEALER_SEAT;
      res        <= '0;
      ready      <= 1'b0;
      deal_s1    <= 1'b1;
      deal_s2    <= 1'b1;
      deal_press <= 1'b0;
      keys_s1    <= '1;
      keys_s2    <= '1;
      key_press  <= '0;
      for (int i = 0; i < SEATS; i++) begin
        hard[i] <= '0;
        ace[i]  <= 1'b0;
        cnt[i]  <= '0;
        best[i] <= '0;
      end
    end else begin
      state      <= state_next;
      turn       <= turn_next;
      res        <= res_next;
      ready      <= ready_next;
      deal_s1    <= dealKey;
      deal_s2    <= deal_s1;
      deal_press <= deal_s2 & ~deal_s1;
      keys_s1    <= playerKeys;
      keys_s2    <= keys_s1;
      key_press  <= keys_s2 & ~keys_s1;
      for (int i = 0; i < SEATS; i++) begin
        hard[i] <= hard_next[i];
        ace[i]  <= ace_next[i];
        cnt[i]  <= cnt_next[i];
        best[i] <= best_next[i];
      end
    end
  end

endmodule
